// File: rtl/switch_debouncer_if.sv
// ---------------------------------------------------------------------------
// switch_debouncer_if
// Bundles the switch-side signals of the debouncer so the board top and the
// PIO wrapper can hand them around as a single port.
//
// Signals:
//   sw_raw  [WIDTH] raw asynchronous switch pins (driven by the board side)
//   sw_out  [WIDTH] debounced switch level, feeds the PIO in_port
//   rise    [WIDTH] one-cycle pulse per bit on a debounced 0->1 transition
//   fall    [WIDTH] one-cycle pulse per bit on a debounced 1->0 transition
//   changed         single-cycle OR of all rise/fall pulses
//
// Modports:
//   master - board/consumer side: drives sw_raw, observes the results
//   slave  - debouncer side: samples sw_raw, drives the results
// ---------------------------------------------------------------------------
interface switch_debouncer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] sw_raw;
    logic [WIDTH-1:0] sw_out;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic             changed;

    modport master (
        output sw_raw,
        input  sw_out,
        input  rise,
        input  fall,
        input  changed
    );

    modport slave (
        input  sw_raw,
        output sw_out,
        output rise,
        output fall,
        output changed
    );
endinterface

// File: rtl/switch_debouncer.sv
// ---------------------------------------------------------------------------
// switch_debouncer
// Conditions the raw slide-switch pins before they reach the switch PIO.
// Each pin is brought into the clk domain through a two-flop synchroniser and
// then filtered by a per-bit stability counter: the debounced level only
// follows the synchronised level after it has differed for STABLE_CYCLES
// consecutive clocks. One-cycle rise/fall pulses and a combined 'changed'
// flag are produced on the same edge that the debounced level moves.
//
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   io_sw    switch_debouncer_if.slave
//              sw_raw  in  raw asynchronous switch pins
//              sw_out  out debounced level
//              rise    out per-bit 0->1 pulse
//              fall    out per-bit 1->0 pulse
//              changed out OR of rise|fall, same cycle
//
// Parameters:
//   WIDTH          number of switch bits
//   STABLE_CYCLES  clocks a bit must be stable before sw_out follows (>= 1)
//   CNT_W          per-bit counter width, must hold STABLE_CYCLES-1
//   RESET_VAL      reset value of the synchroniser flops and sw_out
// ---------------------------------------------------------------------------
module switch_debouncer #(
    parameter int               WIDTH         = 8,
    parameter int               STABLE_CYCLES = 500000,
    parameter int               CNT_W         = 20,
    parameter logic [WIDTH-1:0] RESET_VAL     = '0
) (
    input  logic               clk,
    input  logic               reset_n,
    switch_debouncer_if.slave  io_sw
);

    // Terminal count: the cycle on which the stable window completes.
    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(STABLE_CYCLES - 1);

    // Elaboration-time parameter sanity checks.
    if (STABLE_CYCLES < 1) begin : g_badStableCycles
        $error("switch_debouncer: STABLE_CYCLES must be at least 1");
    end
    if (CNT_W < 31 && (STABLE_CYCLES - 1) >= (1 << CNT_W)) begin : g_badCntWidth
        $error("switch_debouncer: CNT_W too narrow for STABLE_CYCLES-1");
    end

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_swOut;
    logic [WIDTH-1:0] r_rise;
    logic [WIDTH-1:0] r_fall;
    logic             r_changed;
    logic [CNT_W-1:0] r_cnt [WIDTH];

    logic [WIDTH-1:0] w_swNext;
    logic [WIDTH-1:0] w_riseNext;
    logic [WIDTH-1:0] w_fallNext;
    logic [CNT_W-1:0] w_cntNext [WIDTH];

    // Per-bit filter. Any cycle where the synchronised level matches the
    // debounced level throws away the partial count, so a bounce must
    // restart the whole window from zero.
    always_comb begin
        w_swNext   = r_swOut;
        w_riseNext = '0;
        w_fallNext = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_cntNext[i] = '0;
            if (r_sync2[i] == r_swOut[i]) begin
                w_cntNext[i] = '0;
            end else if (r_cnt[i] == LP_LAST) begin
                w_cntNext[i]  = '0;
                w_swNext[i]   = r_sync2[i];
                w_riseNext[i] = r_sync2[i];
                w_fallNext[i] = ~r_sync2[i];
            end else begin
                w_cntNext[i] = r_cnt[i] + CNT_W'(1);
            end
        end
    end

    // Synchroniser chain plus registered filter state and pulses. The pulses
    // are computed from next-state logic so they line up with the sw_out edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1   <= RESET_VAL;
            r_sync2   <= RESET_VAL;
            r_swOut   <= RESET_VAL;
            r_rise    <= '0;
            r_fall    <= '0;
            r_changed <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync1   <= io_sw.sw_raw;
            r_sync2   <= r_sync1;
            r_swOut   <= w_swNext;
            r_rise    <= w_riseNext;
            r_fall    <= w_fallNext;
            r_changed <= |(w_riseNext | w_fallNext);
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= w_cntNext[i];
            end
        end
    end

    assign io_sw.sw_out  = r_swOut;
    assign io_sw.rise    = r_rise;
    assign io_sw.fall    = r_fall;
    assign io_sw.changed = r_changed;

endmodule

// File: tb/tb_switch_debouncer.sv
// ---------------------------------------------------------------------------
// tb_switch_debouncer
// Two debouncer instances: the main one with a 4-cycle window and a
// minimum-window one (STABLE_CYCLES=1, CNT_W=1). Each step drives inputs
// one time unit after a rising edge, pushes the expected post-edge outputs
// into a queue, and after the next rising edge pops and compares them.
// Latencies below count the edge that first captures a new level into the
// synchroniser as edge 1; with a 4-cycle window sw_out moves on edge 6.
// ---------------------------------------------------------------------------
module tb_switch_debouncer;

    typedef struct {
        logic       rstN;
        logic       dut;
        logic [7:0] raw;
        logic [7:0] out;
        logic [7:0] rise;
        logic [7:0] fall;
        logic       chg;
    } vec_t;

    logic clk;
    logic reset_n;

    int passCount;
    int totalCount;
    int stepNo;

    vec_t vecs[$];
    vec_t expQ[$];

    switch_debouncer_if #(.WIDTH(8)) ifMain ();
    switch_debouncer_if #(.WIDTH(8)) ifMin ();

    switch_debouncer #(
        .WIDTH(8), .STABLE_CYCLES(4), .CNT_W(3), .RESET_VAL(8'h00)
    ) dutMain (
        .clk(clk), .reset_n(reset_n), .io_sw(ifMain.slave)
    );

    switch_debouncer #(
        .WIDTH(8), .STABLE_CYCLES(1), .CNT_W(1), .RESET_VAL(8'h00)
    ) dutMin (
        .clk(clk), .reset_n(reset_n), .io_sw(ifMin.slave)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Absolute time limit so the bench can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkVal(input string name, input logic [7:0] act, input logic [7:0] exp);
        totalCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic addVec(input logic rstN, input logic dut, input logic [7:0] raw,
                          input logic [7:0] out, input logic [7:0] rise,
                          input logic [7:0] fall, input logic chg, input int n);
        vec_t v;
        v = '{rstN: rstN, dut: dut, raw: raw, out: out, rise: rise, fall: fall, chg: chg};
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endtask

    // Drive one step's inputs and record what the outputs must be after the edge.
    task automatic applyStimulus(input vec_t v);
        reset_n = v.rstN;
        if (v.dut) ifMin.sw_raw = v.raw;
        else       ifMain.sw_raw = v.raw;
        expQ.push_back(v);
    endtask

    // Wait for the edge, then pop the oldest expectation and compare.
    task automatic checkOutput();
        vec_t e;
        logic [7:0] aOut, aRise, aFall;
        logic       aChg;
        @(posedge clk);
        #1;
        if (expQ.size() == 0) begin
            totalCount++;
            $display("[TB] FAIL step%0d scoreboard: got empty queue, expected an entry", stepNo);
        end else begin
            e = expQ.pop_front();
            if (e.dut) begin
                aOut = ifMin.sw_out; aRise = ifMin.rise; aFall = ifMin.fall; aChg = ifMin.changed;
            end else begin
                aOut = ifMain.sw_out; aRise = ifMain.rise; aFall = ifMain.fall; aChg = ifMain.changed;
            end
            checkVal($sformatf("step%0d sw_out", stepNo), aOut, e.out);
            checkVal($sformatf("step%0d rise", stepNo), aRise, e.rise);
            checkVal($sformatf("step%0d fall", stepNo), aFall, e.fall);
            checkVal($sformatf("step%0d changed", stepNo), {7'b0, aChg}, {7'b0, e.chg});
        end
        stepNo++;
    endtask

    task automatic runStep(input logic rstN, input logic dut, input logic [7:0] raw,
                           input logic [7:0] out, input logic [7:0] rise,
                           input logic [7:0] fall, input logic chg);
        vec_t v;
        v = '{rstN: rstN, dut: dut, raw: raw, out: out, rise: rise, fall: fall, chg: chg};
        applyStimulus(v);
        checkOutput();
    endtask

    initial begin
        passCount  = 0;
        totalCount = 0;
        stepNo     = 0;
        reset_n       = 1'b0;
        ifMain.sw_raw = 8'hFF;
        ifMin.sw_raw  = 8'h00;

        // Reset held with all pins high, then release: all bits rise on edge 6.
        addVec(0, 0, 8'hFF, 8'h00, 8'h00, 8'h00, 0, 2);
        addVec(1, 0, 8'hFF, 8'h00, 8'h00, 8'h00, 0, 5);
        addVec(1, 0, 8'hFF, 8'hFF, 8'hFF, 8'h00, 1, 1);
        addVec(1, 0, 8'hFF, 8'hFF, 8'h00, 8'h00, 0, 1);
        // All pins low again: all bits fall.
        addVec(1, 0, 8'h00, 8'hFF, 8'h00, 8'h00, 0, 5);
        addVec(1, 0, 8'h00, 8'h00, 8'h00, 8'hFF, 1, 1);
        addVec(1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1);
        // Clean press on bit 3.
        addVec(1, 0, 8'h08, 8'h00, 8'h00, 8'h00, 0, 5);
        addVec(1, 0, 8'h08, 8'h08, 8'h08, 8'h00, 1, 1);
        addVec(1, 0, 8'h08, 8'h08, 8'h00, 8'h00, 0, 1);
        // Move to 0x0F, then swap every bit at once to 0xF0.
        addVec(1, 0, 8'h0F, 8'h08, 8'h00, 8'h00, 0, 5);
        addVec(1, 0, 8'h0F, 8'h0F, 8'h07, 8'h00, 1, 1);
        addVec(1, 0, 8'h0F, 8'h0F, 8'h00, 8'h00, 0, 1);
        addVec(1, 0, 8'hF0, 8'h0F, 8'h00, 8'h00, 0, 5);
        addVec(1, 0, 8'hF0, 8'hF0, 8'hF0, 8'h0F, 1, 1);
        addVec(1, 0, 8'hF0, 8'hF0, 8'h00, 8'h00, 0, 1);
        // Back to all low before the bounce sequence.
        addVec(1, 0, 8'h00, 8'hF0, 8'h00, 8'h00, 0, 5);
        addVec(1, 0, 8'h00, 8'h00, 8'h00, 8'hF0, 1, 1);
        addVec(1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1);

        #1;
        checkVal("reset async sw_out", ifMain.sw_out, 8'h00);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput();
        end

        // Bounce on bit 0: high 3, low 2, then high and hold. The 3-cycle
        // burst reaches count 3 but never the terminal edge.
        repeat (3) runStep(1, 0, 8'h01, 8'h00, 8'h00, 8'h00, 0);
        repeat (2) runStep(1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0);
        repeat (5) runStep(1, 0, 8'h01, 8'h00, 8'h00, 8'h00, 0);
        runStep(1, 0, 8'h01, 8'h01, 8'h01, 8'h00, 1);
        repeat (2) runStep(1, 0, 8'h01, 8'h01, 8'h00, 8'h00, 0);

        // Reset mid-count: bit 5 has counted to 2 when reset hits.
        repeat (4) runStep(1, 0, 8'h21, 8'h01, 8'h00, 8'h00, 0);
        reset_n = 1'b0;
        #1;
        checkVal("midreset immediate sw_out", ifMain.sw_out, 8'h00);
        checkVal("midreset immediate rise", ifMain.rise, 8'h00);
        checkVal("midreset immediate changed", {7'b0, ifMain.changed}, 8'h00);
        repeat (2) runStep(0, 0, 8'h21, 8'h00, 8'h00, 8'h00, 0);
        repeat (5) runStep(1, 0, 8'h21, 8'h00, 8'h00, 8'h00, 0);
        runStep(1, 0, 8'h21, 8'h21, 8'h21, 8'h00, 1);
        runStep(1, 0, 8'h21, 8'h21, 8'h00, 8'h00, 0);

        // Minimum window: level change shows on edge 3, then a one-cycle
        // glitch on bit 1 comes through as a rise followed by a fall.
        repeat (2) runStep(1, 1, 8'h01, 8'h00, 8'h00, 8'h00, 0);
        runStep(1, 1, 8'h01, 8'h01, 8'h01, 8'h00, 1);
        runStep(1, 1, 8'h01, 8'h01, 8'h00, 8'h00, 0);
        runStep(1, 1, 8'h03, 8'h01, 8'h00, 8'h00, 0);
        runStep(1, 1, 8'h01, 8'h01, 8'h00, 8'h00, 0);
        runStep(1, 1, 8'h01, 8'h03, 8'h02, 8'h00, 1);
        runStep(1, 1, 8'h01, 8'h01, 8'h00, 8'h02, 1);
        runStep(1, 1, 8'h01, 8'h01, 8'h00, 8'h00, 0);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
